sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Round-robin arbiter sharing one single-port SoC SRAM macro (req/we/addr/wdata/wmask in, rdata/rvalid out, always ready) between NumReq requesters, e.g. two tlul_adapter_sram instances.
- Grants at most one request per cycle and tracks the owner of each in-flight access in a ReadLatency-deep tag pipeline.
- Routes each returning rvalid only to the requester that issued the access.
- Flags protocol violations with a sticky error bit.

Parameters:
- NumReq, 2, number of requesters (2..8)
- Aw, 12, SRAM word address width
- Dw, 32, SRAM data width; wmask width Dw/8
- ReadLatency, 1, cycles from accepted SRAM req to sram_rvalid_i (1..4)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- req_i  in  NumReq  per-requester access request
- we_i  in  NumReq  per-requester write enable
- addr_i  in  NumReq*Aw  per-requester word address, requester k in bits [k*Aw +: Aw]
- wdata_i  in  NumReq*Dw  per-requester write data
- wmask_i  in  NumReq*Dw/8  per-requester byte mask
- gnt_o  out  NumReq  one-hot-or-zero grant; request accepted when req_i[k] & gnt_o[k]
- rvalid_o  out  NumReq  per-requester response valid
- rdata_o  out  Dw  response data, broadcast to all requesters
- sram_req_o  out  1  SRAM request
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  Aw  SRAM address
- sram_wdata_o  out  Dw  SRAM write data
- sram_wmask_o  out  Dw/8  SRAM byte mask
- sram_rdata_i  in  Dw  SRAM read data
- sram_rvalid_i  in  1  SRAM response valid (reads and writes)
- err_o  out  1  sticky protocol error

Behaviour:
- Clock clk_i, reset rst_ni: single clock; reset asynchronous, active-low.
- Reset values:
  - Priority pointer ptr = 0.
  - Tag pipeline all invalid.
  - err_o = 0, gnt_o = 0, rvalid_o = 0.
  - sram_req_o = 0; sram_we_o, sram_addr_o, sram_wdata_o, sram_wmask_o = 0.
- Grant (combinational, same cycle):
  - Search req_i starting at index ptr, ascending, wrapping modulo NumReq.
  - The first asserted requester k gets gnt_o[k] = 1. No request -> gnt_o = 0.
- SRAM drive:
  - sram_req_o = |gnt_o.
  - we/addr/wdata/wmask are muxed from the granted requester.
  - All SRAM-side fields are 0 when there is no grant (no X propagation).
- Pointer update (registered): on a grant to k, ptr <= (k+1) mod NumReq; otherwise ptr holds.
- Fairness: a continuously requesting requester is granted within NumReq cycles.
- Requester protocol: requesters may drop req_i without a grant; the arbiter must not depend on request hold.
- Tag pipeline:
  - ReadLatency stages, each holding {valid, id[clog2(NumReq)-1:0]}.
  - Stage 0 loads {sram_req_o, granted id}; stages shift every cycle.
  - The last stage aligns with sram_rvalid_i.
- Response routing:
  - rvalid_o[id] = sram_rvalid_i & last.valid; all other rvalid_o bits 0.
  - rdata_o = sram_rdata_i, passed through unregistered.
- Throughput: one access per cycle sustained; back-to-back accesses from different requesters are fully pipelined.
- Error (sticky, cleared only by reset):
  - err_o <= 1 when sram_rvalid_i & !last.valid (unexpected response).
  - err_o <= 1 when last.valid & !sram_rvalid_i (lost response).
  - Routing continues normally after an error.
- Simultaneous events: a new grant and a returning response in the same cycle are independent and both complete.
- Reset mid-operation: in-flight tags are discarded; no rvalid_o is issued for them after reset deassertion.

Test Plan:
- Reset then idle, ReadLatency=1: all outputs 0 for 10 cycles; err_o stays 0.
- Single read, requester 1, addr 0x0A5, model returns 0xDEADBEEF next cycle: gnt_o=2'b10 in cycle 0; sram_addr_o=0x0A5, sram_we_o=0; rvalid_o=2'b10 and rdata_o=0xDEADBEEF in cycle 1.
- Both requesters hold req for 6 cycles from reset: grants alternate 01,10,01,10,01,10; each rvalid_o alternates one cycle later, matching ids.
- Write, requester 0, addr 0x010, wdata 0x12345678, wmask 4'b0011: SRAM sees exactly these values with we=1; rvalid_o[0] pulses once one cycle later.
- Protocol errors: inject sram_rvalid_i with no in-flight access -> err_o=1 next cycle and stays 1; with ReadLatency=3, suppress an expected rvalid -> err_o=1.
- Reset mid-flight, ReadLatency=3: two accesses issued, rst_ni asserted for 1 cycle -> no rvalid_o afterwards and ptr restarts at 0 (next contended grant goes to requester 0).

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NumReq requesters.
// Tracks the owner of every in-flight access so each response returns to its issuer.
module sram_port_arbiter #(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned Aw          = 12,
  parameter int unsigned Dw          = 32,
  parameter int unsigned ReadLatency = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0]        we_i,
  input  logic [NumReq*Aw-1:0]     addr_i,
  input  logic [NumReq*Dw-1:0]     wdata_i,
  input  logic [NumReq*Dw/8-1:0]   wmask_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [NumReq-1:0]        rvalid_o,
  output logic [Dw-1:0]            rdata_o,
  output logic                     sram_req_o,
  output logic                     sram_we_o,
  output logic [Aw-1:0]            sram_addr_o,
  output logic [Dw-1:0]            sram_wdata_o,
  output logic [Dw/8-1:0]          sram_wmask_o,
  input  logic [Dw-1:0]            sram_rdata_i,
  input  logic                     sram_rvalid_i,
  output logic                     err_o
);

  localparam int unsigned IdW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned Mw  = Dw / 8;

  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] gnt_id;
  logic [IdW-1:0] idx;
  logic           gnt_any;

  logic [ReadLatency-1:0]          tag_valid_q;
  logic [ReadLatency-1:0][IdW-1:0] tag_id_q;
  logic                            last_valid;
  logic [IdW-1:0]                  last_id;
  logic                            err_q;

  // Scan from the priority pointer upward, wrapping; first requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = IdW'((32'(ptr_q) + i) % NumReq);
      if (!gnt_any && req_i[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (gnt_any) gnt_o[gnt_id] = 1'b1;
  end

  // All SRAM-side fields are forced to zero when idle.
  always_comb begin
    sram_req_o   = gnt_any;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wmask_o = '0;
    if (gnt_any) begin
      sram_we_o    = we_i[gnt_id];
      sram_addr_o  = addr_i[32'(gnt_id) * Aw +: Aw];
      sram_wdata_o = wdata_i[32'(gnt_id) * Dw +: Dw];
      sram_wmask_o = wmask_i[32'(gnt_id) * Mw +: Mw];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (32'(gnt_id) == NumReq - 1) ? '0 : gnt_id + IdW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      tag_valid_q <= '0;
      tag_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q          <= ptr_d;
      tag_valid_q[0] <= gnt_any;
      tag_id_q[0]    <= gnt_id;
      for (int unsigned s = 1; s < ReadLatency; s++) begin
        tag_valid_q[s] <= tag_valid_q[s-1];
        tag_id_q[s]    <= tag_id_q[s-1];
      end
      // Unexpected or missing response; sticky until reset.
      err_q <= err_q | (sram_rvalid_i ^ last_valid);
    end
  end

  assign last_valid = tag_valid_q[ReadLatency-1];
  assign last_id    = tag_id_q[ReadLatency-1];

  always_comb begin
    rvalid_o = '0;
    if (sram_rvalid_i && last_valid) rvalid_o[last_id] = 1'b1;
  end

  assign rdata_o = sram_rdata_i;
  assign err_o   = err_q;

endmodule
